// File: rtl/przerwanie_pkg.sv
// Shared definitions for the interrupt controller and the core-side responder:
// vector encodings and the responder state type.
package przerwanie_pkg;

  localparam logic [7:0] VEC_EXT   = 8'h02;
  localparam logic [7:0] VEC_TIMER = 8'h04;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    RET_POP
  } isr_state_t;

endpackage

// File: rtl/stos_powrotu.sv
// Hardware return-address LIFO: DEPTH entries of AW bits, pointer-only reset,
// combinational top-of-stack read.
module stos_powrotu #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] top
);

  localparam int PW  = $clog2(DEPTH);
  localparam int SPW = PW + 1;

  logic [AW-1:0]  stack_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [PW-1:0]  top_idx;

  assign full    = (sp_q == SPW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = sp_q[PW-1:0] - PW'(1);
  assign top     = stack_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (push && !full)
      sp_d = sp_q + SPW'(1);
    else if (pop && !empty)
      sp_d = sp_q - SPW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // NOTE: the storage array is deliberately not reset; an empty pointer already
  // makes every entry unreachable, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push && !full)
      stack_q[sp_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/obsluga_przerwan.sv
// Core-side interrupt responder: latches requests, enters the ISR at an
// instruction boundary via a return stack, and returns on RETI.
module obsluga_przerwan
  import przerwanie_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          przerwanie,
  input  logic [AW-1:0] int_vector,
  input  logic          instr_boundary,
  input  logic [AW-1:0] ret_addr,
  input  logic          reti,
  output logic          pc_load,
  output logic [AW-1:0] pc_value,
  output logic          flush,
  output logic          int_disable,
  output logic          int_enable,
  output logic          in_isr,
  output logic          int_lost,
  output logic          stack_err
);

  isr_state_t    state_q, state_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_vec_q, pend_vec_d;
  logic [AW-1:0] ret_q, ret_d;
  logic          pc_load_q, pc_load_d;
  logic [AW-1:0] pc_value_q, pc_value_d;
  logic          int_disable_q, int_disable_d;
  logic          int_enable_q, int_enable_d;
  logic          int_lost_q, int_lost_d;
  logic          stack_err_q, stack_err_d;

  logic          push, pop, full, empty;
  logic [AW-1:0] top;
  logic          boundary_ok, pend_live;

  stos_powrotu #(.AW(AW), .DEPTH(DEPTH)) u_stos (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ret_q),
    .full  (full),
    .empty (empty),
    .top   (top)
  );

  // A boundary seen while the redirect is still on the bus belongs to flushed code.
  assign boundary_ok = instr_boundary && !pc_load_q;
  assign pend_live   = pend_q && (state_q != ENTRY);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_vec_d    = pend_vec_q;
    ret_d         = ret_q;
    push          = 1'b0;
    pop           = 1'b0;
    pc_load_d     = 1'b0;
    pc_value_d    = '0;
    int_disable_d = 1'b0;
    int_enable_d  = 1'b0;
    int_lost_d    = 1'b0;
    stack_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (boundary_ok && reti) begin
          if (!empty) state_d     = RET_POP;
          else        stack_err_d = 1'b1;
        end else if (boundary_ok && pend_q && !full) begin
          state_d = ENTRY;
          ret_d   = ret_addr;
        end
      end
      ENTRY: begin
        push          = 1'b1;
        pend_d        = 1'b0;
        pc_load_d     = 1'b1;
        pc_value_d    = pend_vec_q;
        int_disable_d = 1'b1;
        state_d       = IDLE;
      end
      RET_POP: begin
        pop          = 1'b1;
        pc_load_d    = 1'b1;
        pc_value_d   = top;
        int_enable_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Request latch runs in every state; a lower vector number has priority.
    if (przerwanie) begin
      if (!pend_live) begin
        pend_d     = 1'b1;
        pend_vec_d = int_vector;
      end else begin
        int_lost_d = 1'b1;
        if (int_vector < pend_vec_q)
          pend_vec_d = int_vector;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pend_q        <= 1'b0;
      pend_vec_q    <= '0;
      ret_q         <= '0;
      pc_load_q     <= 1'b0;
      pc_value_q    <= '0;
      int_disable_q <= 1'b0;
      int_enable_q  <= 1'b0;
      int_lost_q    <= 1'b0;
      stack_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_vec_q    <= pend_vec_d;
      ret_q         <= ret_d;
      pc_load_q     <= pc_load_d;
      pc_value_q    <= pc_value_d;
      int_disable_q <= int_disable_d;
      int_enable_q  <= int_enable_d;
      int_lost_q    <= int_lost_d;
      stack_err_q   <= stack_err_d;
    end
  end

  assign pc_load     = pc_load_q;
  assign pc_value    = pc_value_q;
  assign flush       = pc_load_q;
  assign int_disable = int_disable_q;
  assign int_enable  = int_enable_q;
  assign int_lost    = int_lost_q;
  assign stack_err   = stack_err_q;
  assign in_isr      = !empty;

endmodule
